mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between an instruction-fetch requester (i_*)
// and a load/store requester (d_*). Only one transaction is in flight at a
// time. Simultaneous requests are granted alternately, starting with the
// data side after reset. A watchdog flags transactions that linger in the
// memory handshake for too long.
//
// Ports
//   clk, rst              : clock and synchronous active-high reset
//   i_req, i_addr         : fetch request (held until i_valid) and address
//   i_rdata, i_valid      : fetch data and its one-cycle completion pulse
//   d_req, d_we           : load/store request (held until d_valid), byte mask
//   d_addr, d_wdata       : data address and store data
//   d_rdata, d_valid      : load data and load/store completion pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata   : transaction presented to the memory port
//   mem_ready             : memory accepts while mem_req is high
//   mem_rvalid, mem_rdata : read return, zero or more cycles after acceptance
//   stall                 : pipeline stall, high while any request is pending
//   timeout_err           : sticky watchdog flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  // load/store side
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  // shared memory port
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        stall,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic SIDE_FETCH = 1'b0;
  localparam logic SIDE_DATA  = 1'b1;

  state_e      state_q, state_d;
  logic        side_q, side_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        i_valid_q, i_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        timeout_err_q, timeout_err_d;

  logic        i_elig;
  logic        d_elig;
  logic        grant_data;
  logic        is_store;
  logic        complete_read;

  // A requester that is seeing its own valid pulse this cycle has already
  // been served; its req is still high only because it has not dropped it yet.
  assign i_elig = i_req & ~i_valid_q;
  assign d_elig = d_req & ~d_valid_q;

  // Data wins when it is the only contender, or when fetch won last time.
  assign grant_data = d_elig & (~i_elig | (last_grant_q == SIDE_FETCH));

  // A fetch always latches a zero mask, so a nonzero mask marks a store.
  assign is_store = |mem_we_q;

  // Next-state, field latching, completion pulses and watchdog.
  always_comb begin
    state_d       = state_q;
    side_d        = side_q;
    last_grant_d  = last_grant_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_valid_d     = 1'b0;
    d_valid_d     = 1'b0;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    complete_read = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_elig | d_elig) begin
          state_d      = ST_ISSUE;
          side_d       = grant_data;
          last_grant_d = grant_data;
          mem_addr_d   = grant_data ? d_addr  : i_addr;
          mem_we_d     = grant_data ? d_we    : 4'b0000;
          mem_wdata_d  = grant_data ? d_wdata : 32'h0000_0000;
          wdog_d       = 8'd0;
        end
      end

      ST_ISSUE: begin
        if (mem_ready) begin
          if (is_store) begin
            // Stores have no read return, so they finish on acceptance
            // and any mem_rvalid seen here belongs to nobody.
            d_valid_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (mem_rvalid) begin
            complete_read = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (mem_rvalid) begin
          complete_read = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Route returned read data to whichever side owns the transaction.
    if (complete_read) begin
      state_d = ST_IDLE;
      if (side_q == SIDE_DATA) begin
        d_valid_d = 1'b1;
        d_rdata_d = mem_rdata;
      end else begin
        i_valid_d = 1'b1;
        i_rdata_d = mem_rdata;
      end
    end

    // Watchdog counts every cycle spent in the memory handshake; the flag
    // rises on the same edge the counter saturates.
    if (state_q != ST_IDLE) begin
      wdog_d = (wdog_q == 8'hFF) ? wdog_q : (wdog_q + 8'd1);
      if (wdog_d == 8'hFF) begin
        timeout_err_d = 1'b1;
      end
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      side_q        <= SIDE_FETCH;
      last_grant_q  <= SIDE_FETCH;
      mem_we_q      <= 4'b0000;
      mem_addr_q    <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
      i_valid_q     <= 1'b0;
      d_valid_q     <= 1'b0;
      i_rdata_q     <= 32'h0000_0000;
      d_rdata_q     <= 32'h0000_0000;
      wdog_q        <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      side_q        <= side_d;
      last_grant_q  <= last_grant_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      i_valid_q     <= i_valid_d;
      d_valid_q     <= d_valid_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = (state_q == ST_ISSUE);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_valid     = i_valid_q;
  assign d_valid     = d_valid_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign timeout_err = timeout_err_q;

  // Purely combinational so the pipeline sees held requests even in reset.
  assign stall = (i_req & ~i_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs change 1ns after each rising
// edge; outputs are sampled at that same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_valid    (i_valid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_req: got %0h want 0", mem_req); end
    total++; if (mem_we !== 4'h0) begin bad++; $display("[TB] FAIL rst_mem_we: got %0h want 0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_mem_addr: got %0h want 0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_mem_wdata: got %0h want 0", mem_wdata); end
    total++; if (i_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_i_valid: got %0h want 0", i_valid); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_d_valid: got %0h want 0", d_valid); end
    total++; if (i_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_i_rdata: got %0h want 0", i_rdata); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_d_rdata: got %0h want 0", d_rdata); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeout: got %0h want 0", timeout_err); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_idle: got %0h want 0", stall); end
    // stall reflects a held request even while reset is asserted
    i_req = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL rst_stall_held: got %0h want 1", stall); end
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_grant: got %0h want 0", mem_req); end
    i_req = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_contention();
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h100; d_wdata = 32'h0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL cont_stall0: got %0h want 1", stall); end
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL cont_issue_d: got %0h want 1", mem_req); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("[TB] FAIL cont_addr_d: got %0h want 100", mem_addr); end
    total++; if (mem_we !== 4'h0) begin bad++; $display("[TB] FAIL cont_we_d: got %0h want 0", mem_we); end
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL cont_stall1: got %0h want 1", stall); end
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL cont_wait_req: got %0h want 0", mem_req); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL cont_wait_dv: got %0h want 0", d_valid); end
    mem_ready = 1'b0;
    tick();
    total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL cont_wait_dv2: got %0h want 0", d_valid); end
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL cont_stall2: got %0h want 1", stall); end
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA0001;
    tick();
    total++; if (d_valid !== 1'b1) begin bad++; $display("[TB] FAIL cont_dvalid: got %0h want 1", d_valid); end
    total++; if (d_rdata !== 32'hAAAA0001) begin bad++; $display("[TB] FAIL cont_drdata: got %0h want aaaa0001", d_rdata); end
    total++; if (i_valid !== 1'b0) begin bad++; $display("[TB] FAIL cont_ivalid_early: got %0h want 0", i_valid); end
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL cont_stall3: got %0h want 1", stall); end
    d_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1;
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL cont_issue_i: got %0h want 1", mem_req); end
    total++; if (mem_addr !== 32'h40) begin bad++; $display("[TB] FAIL cont_addr_i: got %0h want 40", mem_addr); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL cont_dv_pulse: got %0h want 0", d_valid); end
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL cont_stall4: got %0h want 1", stall); end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
    tick();
    total++; if (i_valid !== 1'b1) begin bad++; $display("[TB] FAIL cont_ivalid: got %0h want 1", i_valid); end
    total++; if (i_rdata !== 32'h5555AAAA) begin bad++; $display("[TB] FAIL cont_irdata: got %0h want 5555aaaa", i_rdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL cont_stall_end: got %0h want 0", stall); end
    i_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick();
    total++; if (i_valid !== 1'b0) begin bad++; $display("[TB] FAIL cont_iv_pulse: got %0h want 0", i_valid); end
    total++; if (i_rdata !== 32'h5555AAAA) begin bad++; $display("[TB] FAIL cont_irdata_hold: got %0h want 5555aaaa", i_rdata); end
    total++; if (d_rdata !== 32'hAAAA0001) begin bad++; $display("[TB] FAIL cont_drdata_hold: got %0h want aaaa0001", d_rdata); end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL st_req[%0d]: got %0h want 1", k, mem_req); end
      total++; if (mem_we !== 4'b0011) begin bad++; $display("[TB] FAIL st_we[%0d]: got %0h want 3", k, mem_we); end
      total++; if (mem_addr !== 32'h20) begin bad++; $display("[TB] FAIL st_addr[%0d]: got %0h want 20", k, mem_addr); end
      total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL st_wdata[%0d]: got %0h want deadbeef", k, mem_wdata); end
      total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL st_dv_early[%0d]: got %0h want 0", k, d_valid); end
      if (k == 3) begin
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
      end
      tick();
    end
    total++; if (d_valid !== 1'b1) begin bad++; $display("[TB] FAIL st_dvalid: got %0h want 1", d_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL st_req_after: got %0h want 0", mem_req); end
    total++; if (d_rdata !== 32'hAAAA0001) begin bad++; $display("[TB] FAIL st_drdata_kept: got %0h want aaaa0001", d_rdata); end
    d_req = 1'b0; d_we = 4'h0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();
    total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL st_dv_pulse: got %0h want 0", d_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL st_idle: got %0h want 0", mem_req); end
  endtask

  task automatic test_same_cycle();
    i_req = 1'b1; i_addr = 32'h80;
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL sc_req: got %0h want 1", mem_req); end
    total++; if (mem_addr !== 32'h80) begin bad++; $display("[TB] FAIL sc_addr: got %0h want 80", mem_addr); end
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    total++; if (i_valid !== 1'b1) begin bad++; $display("[TB] FAIL sc_ivalid: got %0h want 1", i_valid); end
    total++; if (i_rdata !== 32'h12345678) begin bad++; $display("[TB] FAIL sc_irdata: got %0h want 12345678", i_rdata); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL sc_dvalid: got %0h want 0", d_valid); end
    i_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();
    total++; if (i_valid !== 1'b0) begin bad++; $display("[TB] FAIL sc_iv_pulse: got %0h want 0", i_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL sc_idle: got %0h want 0", mem_req); end
  endtask

  task automatic test_fairness();
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_d;
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h500;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d    = ((k % 2) == 0);
      exp_addr = exp_d ? 32'h500 : 32'h400;
      exp_data = 32'hF000_0000 + 32'(k);
      mem_rdata = exp_data;
      tick();
      total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL fair_req[%0d]: got %0h want 1", k, mem_req); end
      total++; if (mem_addr !== exp_addr) begin bad++; $display("[TB] FAIL fair_addr[%0d]: got %0h want %0h", k, mem_addr, exp_addr); end
      tick();
      total++; if (d_valid !== exp_d) begin bad++; $display("[TB] FAIL fair_dv[%0d]: got %0h want %0h", k, d_valid, exp_d); end
      total++; if (i_valid !== ~exp_d) begin bad++; $display("[TB] FAIL fair_iv[%0d]: got %0h want %0h", k, i_valid, ~exp_d); end
      if (exp_d) begin
        total++; if (d_rdata !== exp_data) begin bad++; $display("[TB] FAIL fair_drdata[%0d]: got %0h want %0h", k, d_rdata, exp_data); end
      end else begin
        total++; if (i_rdata !== exp_data) begin bad++; $display("[TB] FAIL fair_irdata[%0d]: got %0h want %0h", k, i_rdata, exp_data); end
      end
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL fair_idle: got %0h want 0", mem_req); end
  endtask

  task automatic test_reset_mid_wait();
    i_req = 1'b1; i_addr = 32'h600; mem_ready = 1'b1; mem_rvalid = 1'b0;
    tick();
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rw_in_wait: got %0h want 0", mem_req); end
    rst = 1'b1; mem_ready = 1'b0;
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rw_req_rst: got %0h want 0", mem_req); end
    total++; if (i_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rw_irdata_rst: got %0h want 0", i_rdata); end
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    total++; if (i_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_no_valid: got %0h want 0", i_valid); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_no_dvalid: got %0h want 0", d_valid); end
    total++; if (i_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rw_irdata_ign: got %0h want 0", i_rdata); end
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL rw_regrant: got %0h want 1", mem_req); end
    total++; if (mem_addr !== 32'h600) begin bad++; $display("[TB] FAIL rw_addr: got %0h want 600", mem_addr); end
    mem_rvalid = 1'b0;
    tick();
    total++; if (i_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_no_valid2: got %0h want 0", i_valid); end
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL rw_hold_issue: got %0h want 1", mem_req); end
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h06000600;
    tick();
    total++; if (i_valid !== 1'b1) begin bad++; $display("[TB] FAIL rw_ivalid: got %0h want 1", i_valid); end
    total++; if (i_rdata !== 32'h06000600) begin bad++; $display("[TB] FAIL rw_irdata: got %0h want 06000600", i_rdata); end
    i_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    logic exp_to;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h700; mem_ready = 1'b1; mem_rvalid = 1'b0;
    tick();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL wd_c1: got %0h want 0", timeout_err); end
    for (int k = 2; k <= 300; k++) begin
      tick();
      if (k == 2) mem_ready = 1'b0;
      exp_to = (k >= 256);
      total++; if (timeout_err !== exp_to) begin bad++; $display("[TB] FAIL wd_c%0d: got %0h want %0h", k, timeout_err, exp_to); end
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h77770000;
    tick();
    total++; if (d_valid !== 1'b1) begin bad++; $display("[TB] FAIL wd_dvalid: got %0h want 1", d_valid); end
    total++; if (d_rdata !== 32'h77770000) begin bad++; $display("[TB] FAIL wd_drdata: got %0h want 77770000", d_rdata); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL wd_sticky1: got %0h want 1", timeout_err); end
    d_req = 1'b0; mem_rvalid = 1'b0;
    tick();
    tick();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL wd_sticky2: got %0h want 1", timeout_err); end
    rst = 1'b1;
    tick();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL wd_clear: got %0h want 0", timeout_err); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_contention();
    test_store();
    test_same_cycle();
    test_fairness();
    test_reset_mid_wait();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
